qam_sym_sched: RTL

QAM_SYM_SCHED -- requirements
Module: qam_sym_sched

---
 rtl/qam_pkg.sv | 41 ++++
 rtl/qam_sym_slice.sv | 25 ++
 rtl/qam_sym_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/qam_pkg.sv
// Shared types for the QAM symbol scheduler.
// Mode codes, FSM states, buffer geometry and the k lookup.
package qam_pkg;

  localparam int BUF_W  = 64;
  localparam int FILL_W = 7;
  localparam int SYM_W  = 12;

  typedef enum logic [2:0] {
    M_BPSK = 3'd0,
    M_QPSK = 3'd1,
    M_16   = 3'd2,
    M_64   = 3'd3,
    M_256  = 3'd4,
    M_1024 = 3'd5,
    M_4096 = 3'd6,
    M_RSVD = 3'd7
  } mod_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } st_e;

  function automatic logic [3:0] k_of(input logic [2:0] m);
    logic [3:0] k;
    k = 4'd12;
    unique case (1'b1)
      (m == M_BPSK): k = 4'd1;
      (m == M_QPSK): k = 4'd2;
      (m == M_16):   k = 4'd4;
      (m == M_64):   k = 4'd6;
      (m == M_256):  k = 4'd8;
      (m == M_1024): k = 4'd10;
      default:       k = 4'd12;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/qam_sym_slice.sv
// Takes the top k buffer bits and splits them into
// right-aligned I (upper half) and Q (lower half) fields.
module qam_sym_slice
  import qam_pkg::*;
(
  input  logic [SYM_W-1:0] top,
  input  logic [3:0]       k,
  output logic [5:0]       ibits,
  output logic [5:0]       qbits
);

  logic [SYM_W-1:0] sym;
  logic [SYM_W-1:0] qmask;
  logic [2:0]       half;

  // BPSK: half is 0, so Q is empty and the bit lands in I[0]
  always_comb begin
    sym   = top >> (4'd12 - k);
    half  = k[3:1];
    qmask = ~(12'hfff << half);
    qbits = 6'(sym & qmask);
    ibits = 6'(sym >> half);
  end

endmodule

// File: rtl/qam_sym_sched.sv
// Packs a 32-bit word stream into k-bit QAM symbols
// split into I/Q fields, with flush and mode latching.
module qam_sym_sched
  import qam_pkg::*;
(
  input  logic        dclk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  modtyp,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        flush,
  output logic [5:0]  m_ibits,
  output logic [5:0]  m_qbits,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [1:0]  state_o,
  output logic        cfg_err
);

  st_e               state, state_n;
  logic [BUF_W-1:0]  sbuf, sbuf_n;
  logic [BUF_W-1:0]  word_al;
  logic [FILL_W-1:0] fill, fill_n;
  logic [FILL_W-1:0] kf;
  logic [2:0]        mod_q;
  logic [3:0]        k;
  logic              pend, pend_n;
  logic              acc, free, take, pad;
  logic [5:0]        sl_i, sl_q;

  assign k    = k_of(mod_q);
  assign kf   = {3'b000, k};
  assign free = !m_valid || m_ready;

  assign s_ready = !rst && en && (fill <= 7'd32)
                && (state != FLUSH)
                && !(state == IDLE && modtyp == M_RSVD);

  assign acc  = s_valid && s_ready;
  assign take = en && free && (fill >= kf);
  // FLUSH is only entered with fill < k, so take and pad never overlap
  assign pad  = en && free && (state == FLUSH) && (fill != '0);

  assign word_al = {s_data, 32'b0} >> (take ? fill - kf : fill);
  assign state_o = state;

  qam_sym_slice u_slice (
    .top   (sbuf[BUF_W-1 -: SYM_W]),
    .k     (k),
    .ibits (sl_i),
    .qbits (sl_q)
  );

  always_comb begin
    state_n = state;
    pend_n  = pend;
    sbuf_n  = sbuf;
    fill_n  = fill;
    if (take) begin
      sbuf_n = sbuf << k;
      fill_n = fill - kf;
    end
    if (pad) begin
      sbuf_n = '0;
      fill_n = '0;
    end
    if (acc) begin
      sbuf_n = sbuf_n | word_al;
      fill_n = fill_n + 7'd32;
    end
    if (en) begin
      case (state)
        IDLE: if (acc) state_n = RUN;
        RUN: begin
          if (flush || pend) begin
            if (fill == '0) begin
              pend_n = 1'b0;
            end else if (fill < kf && !acc) begin
              state_n = FLUSH;
              pend_n  = 1'b0;
            end else begin
              pend_n = 1'b1;
            end
          end
          if (fill == '0 && !m_valid && !acc) state_n = IDLE;
        end
        FLUSH: begin
          if (fill == '0 && m_valid && m_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (en) state <= state_n;
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      sbuf    <= '0;
      fill    <= '0;
      pend    <= 1'b0;
      mod_q   <= 3'd0;
      cfg_err <= 1'b0;
      m_valid <= 1'b0;
      m_ibits <= '0;
      m_qbits <= '0;
    end else if (en) begin
      sbuf <= sbuf_n;
      fill <= fill_n;
      pend <= pend_n;
      if (state == IDLE) begin
        if (modtyp == M_RSVD) cfg_err <= 1'b1;
        else mod_q <= modtyp;
      end
      if (take || pad) begin
        m_valid <= 1'b1;
        m_ibits <= sl_i;
        m_qbits <= sl_q;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
